// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - byte-stream boot loader that fills instruction memory and releases the core
//
// Receives a framed byte stream (16-bit little-endian word count N, then N
// little-endian 32-bit words) and writes each word into instruction memory.
// The core is held in reset for the whole load and on any load error.
// cpu_reset is released once the final word has been written.
//
// Optional feature macro: IMEM_BOOT_CHECKSUM_EN. When it is defined, the frame
// ends with a 4-byte little-endian sum of all words (mod 2^32). The core is
// released only when that sum matches the words received.
//
// Ports:
//   clk          in   clock, rising edge
//   reset        in   asynchronous active-low reset
//   s_valid      in   byte-stream valid
//   s_data       in   byte-stream data [7:0]
//   s_ready      out  byte-stream ready (registered)
//   reload       in   single-cycle restart request, honoured in RUN/ERR
//   imem_we      out  instruction-memory write strobe (one cycle per word)
//   imem_addr    out  instruction-memory word address [ADDR_WIDTH-1:0]
//   imem_wdata   out  instruction-memory write data [31:0]
//   cpu_reset    out  active-high reset to the processor
//   done         out  load complete, core running
//   error        out  load aborted
//   words_loaded out  words written in the current load [ADDR_WIDTH:0]

module imem_boot_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_valid,
    input  logic [7:0]            s_data,
    output logic                  s_ready,
    input  logic                  reload,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_loaded
);

`ifdef IMEM_BOOT_CHECKSUM_EN
    typedef enum logic [2:0] {
        ST_HDR_LO = 3'd0,
        ST_HDR_HI = 3'd1,
        ST_DATA   = 3'd2,
        ST_CHK    = 3'd3,
        ST_FIN    = 3'd4,
        ST_RUN    = 3'd5,
        ST_ERR    = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_HDR_LO = 3'd0,
        ST_HDR_HI = 3'd1,
        ST_DATA   = 3'd2,
        ST_FIN    = 3'd4,
        ST_RUN    = 3'd5,
        ST_ERR    = 3'd6
    } state_t;
`endif

    localparam logic [ADDR_WIDTH-1:0] IDX_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   WL_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                state;
    state_t                next_state;
    logic                  next_ready;
    logic [1:0]            byte_cnt;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [15:0]           count;
    logic [23:0]           acc;
    logic                  xfer;
    logic                  last_word;
    logic                  bad_count;
    logic [15:0]           hdr_n;
    logic [31:0]           assembled;
`ifdef IMEM_BOOT_CHECKSUM_EN
    logic [31:0]           sum;
`endif

    assign xfer      = s_valid & s_ready;
    assign assembled = {s_data, acc};
    assign hdr_n     = {s_data, count[7:0]};
    // A count of 0 is meaningless and anything above capacity would wrap the word index.
    assign bad_count = (hdr_n == 16'd0) || (32'(hdr_n) > (32'd1 << ADDR_WIDTH));
    assign last_word = (32'(word_idx) == (32'(count) - 32'd1));

    always_comb begin
        next_state = state;
        case (state)
            ST_HDR_LO: if (xfer) next_state = ST_HDR_HI;
            ST_HDR_HI: if (xfer) next_state = bad_count ? ST_ERR : ST_DATA;
            ST_DATA: begin
                if (xfer && byte_cnt == 2'd3 && last_word) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
                    next_state = ST_CHK;
`else
                    next_state = ST_FIN;
`endif
                end
            end
`ifdef IMEM_BOOT_CHECKSUM_EN
            ST_CHK: begin
                if (xfer && byte_cnt == 2'd3)
                    next_state = (assembled == sum) ? ST_FIN : ST_ERR;
            end
`endif
            ST_FIN:    next_state = ST_RUN;
            ST_RUN:    if (reload) next_state = ST_HDR_LO;
            ST_ERR:    if (reload) next_state = ST_HDR_LO;
            default:   next_state = ST_HDR_LO;
        endcase
    end

    // Ready is registered from the next state, so it drops on the very edge
    // that accepts the last frame byte and no extra byte can slip in.
    always_comb begin
        next_ready = 1'b0;
        case (next_state)
            ST_HDR_LO, ST_HDR_HI, ST_DATA: next_ready = 1'b1;
`ifdef IMEM_BOOT_CHECKSUM_EN
            ST_CHK:                        next_ready = 1'b1;
`endif
            default:                       next_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_HDR_LO;
            s_ready      <= 1'b0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            cpu_reset    <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
            byte_cnt     <= 2'd0;
            word_idx     <= '0;
            count        <= 16'd0;
            acc          <= 24'd0;
`ifdef IMEM_BOOT_CHECKSUM_EN
            sum          <= 32'd0;
`endif
        end else begin
            state   <= next_state;
            s_ready <= next_ready;
            imem_we <= 1'b0;
            case (state)
                ST_HDR_LO: if (xfer) count[7:0] <= s_data;
                ST_HDR_HI: begin
                    if (xfer) begin
                        count[15:8] <= s_data;
                        if (bad_count) error <= 1'b1;
                    end
                end
                ST_DATA: begin
                    if (xfer) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0: acc[7:0]   <= s_data;
                            2'd1: acc[15:8]  <= s_data;
                            2'd2: acc[23:16] <= s_data;
                            default: begin
                                imem_we      <= 1'b1;
                                imem_addr    <= word_idx;
                                imem_wdata   <= assembled;
                                words_loaded <= words_loaded + WL_ONE;
`ifdef IMEM_BOOT_CHECKSUM_EN
                                sum          <= sum + assembled;
`endif
                                // Hold the index at N-1 so it never runs past the frame.
                                if (!last_word) word_idx <= word_idx + IDX_ONE;
                            end
                        endcase
                    end
                end
`ifdef IMEM_BOOT_CHECKSUM_EN
                ST_CHK: begin
                    if (xfer) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0: acc[7:0]   <= s_data;
                            2'd1: acc[15:8]  <= s_data;
                            2'd2: acc[23:16] <= s_data;
                            default: if (assembled != sum) error <= 1'b1;
                        endcase
                    end
                end
`endif
                ST_FIN: begin
                    cpu_reset <= 1'b0;
                    done      <= 1'b1;
                end
                ST_RUN: begin
                    if (reload) begin
                        cpu_reset    <= 1'b1;
                        done         <= 1'b0;
                        words_loaded <= '0;
                        word_idx     <= '0;
                        byte_cnt     <= 2'd0;
`ifdef IMEM_BOOT_CHECKSUM_EN
                        sum          <= 32'd0;
`endif
                    end
                end
                ST_ERR: begin
                    cpu_reset <= 1'b1;
                    if (reload) begin
                        error        <= 1'b0;
                        words_loaded <= '0;
                        word_idx     <= '0;
                        byte_cnt     <= 2'd0;
`ifdef IMEM_BOOT_CHECKSUM_EN
                        sum          <= 32'd0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - self-checking bench for imem_boot_loader
module tb_imem_boot_loader;

    localparam int AW = 8;

    logic          clk;
    logic          reset;
    logic          s_valid;
    logic [7:0]    s_data;
    logic          s_ready;
    logic          reload;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_reset;
    logic          done;
    logic          error;
    logic [AW:0]   words_loaded;

    int pass_cnt  = 0;
    int check_cnt = 0;

    logic [7:0]    frame_q[$];
    logic [31:0]   words_q[$];
    logic [AW-1:0] wr_addr_q[$];
    logic [31:0]   wr_data_q[$];

    imem_boot_loader #(.ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .reload       (reload),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_reset    (cpu_reset),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory-side observer: every write strobe seen away from the clock edge.
    always @(negedge clk) begin
        if (imem_we) begin
            wr_addr_q.push_back(imem_addr);
            wr_data_q.push_back(imem_wdata);
        end
    end

    // Reference frame built from the frame format: header, words, optional sum.
    task automatic make_frame(input logic [15:0] n, input logic [31:0] sum_bias);
        logic [31:0] sum;
        sum = 32'd0;
        frame_q.delete();
        frame_q.push_back(n[7:0]);
        frame_q.push_back(n[15:8]);
        foreach (words_q[k]) begin
            sum = sum + words_q[k];
            for (int b = 0; b < 4; b++) frame_q.push_back(8'(words_q[k] >> (8 * b)));
        end
`ifdef IMEM_BOOT_CHECKSUM_EN
        sum = sum + sum_bias;
        for (int b = 0; b < 4; b++) frame_q.push_back(8'(sum >> (8 * b)));
`else
        if (sum_bias != 32'd0) sum = sum + sum_bias;
`endif
    endtask

    // mode 0: full rate, 1: valid every other cycle, 2: random valid + stray reload pulses
    task automatic send_frame(input int mode, output int cycles);
        int i;
        i = 0;
        cycles = 0;
        while (i < frame_q.size() && cycles < 8000) begin
            @(negedge clk);
            cycles++;
            case (mode)
                0:       s_valid = 1'b1;
                1:       s_valid = cycles[0];
                default: s_valid = 1'($urandom_range(0, 1));
            endcase
            s_data = s_valid ? frame_q[i] : 8'($urandom);
            reload = (mode == 2) ? ($urandom_range(0, 7) == 0) : 1'b0;
            if (s_valid && s_ready) i++;
        end
        @(negedge clk);
        s_valid = 1'b0;
        reload  = 1'b0;
        check_cnt++;
        if (i != frame_q.size()) $display("FAIL send_timeout: sent %0d bytes, required %0d", i, frame_q.size());
        else pass_cnt++;
    endtask

    task automatic pulse_reload();
        @(negedge clk);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; s_valid = 1'b0; s_data = 8'd0; reload = 1'b0;
        repeat (2) @(negedge clk);
        check_cnt++; if (s_ready !== 1'b0) $display("FAIL rst_s_ready: got %b want 0", s_ready); else pass_cnt++;
        check_cnt++; if (imem_we !== 1'b0) $display("FAIL rst_we: got %b want 0", imem_we); else pass_cnt++;
        check_cnt++; if (imem_addr !== '0) $display("FAIL rst_addr: got %h want 0", imem_addr); else pass_cnt++;
        check_cnt++; if (imem_wdata !== 32'd0) $display("FAIL rst_wdata: got %h want 0", imem_wdata); else pass_cnt++;
        check_cnt++; if (cpu_reset !== 1'b1) $display("FAIL rst_cpu_reset: got %b want 1", cpu_reset); else pass_cnt++;
        check_cnt++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else pass_cnt++;
        check_cnt++; if (error !== 1'b0) $display("FAIL rst_error: got %b want 0", error); else pass_cnt++;
        check_cnt++; if (words_loaded !== '0) $display("FAIL rst_words: got %0d want 0", words_loaded); else pass_cnt++;
        reset = 1'b1;
        @(negedge clk);
        check_cnt++; if (s_ready !== 1'b1) $display("FAIL rst_ready_rise: got %b want 1", s_ready); else pass_cnt++;
    endtask

    task automatic test_basic_load(input int mode);
        int cyc;
        words_q = '{32'h2008_0005, 32'h2109_0003};
        make_frame(16'd2, 32'd0);
        wr_addr_q.delete(); wr_data_q.delete();
        send_frame(mode, cyc);
        if (mode == 0) begin
            check_cnt++; if (cyc != frame_q.size()) $display("FAIL no_bubbles: got %0d cycles want %0d", cyc, frame_q.size()); else pass_cnt++;
        end
`ifndef IMEM_BOOT_CHECKSUM_EN
        check_cnt++; if (imem_we !== 1'b1 || imem_addr !== 8'd1 || imem_wdata !== 32'h2109_0003)
            $display("FAIL last_write m%0d: got we=%b addr=%h data=%h want 1/01/21090003", mode, imem_we, imem_addr, imem_wdata); else pass_cnt++;
`endif
        check_cnt++; if (s_ready !== 1'b0 || cpu_reset !== 1'b1)
            $display("FAIL end_of_frame m%0d: got ready=%b cpu_reset=%b want 0/1", mode, s_ready, cpu_reset); else pass_cnt++;
        @(negedge clk);
        check_cnt++; if (cpu_reset !== 1'b0 || done !== 1'b1)
            $display("FAIL release m%0d: got cpu_reset=%b done=%b want 0/1", mode, cpu_reset, done); else pass_cnt++;
        check_cnt++; if (words_loaded !== 9'd2) $display("FAIL words m%0d: got %0d want 2", mode, words_loaded); else pass_cnt++;
        check_cnt++; if (wr_addr_q.size() != 2) $display("FAIL write_count m%0d: got %0d want 2", mode, wr_addr_q.size()); else pass_cnt++;
        for (int k = 0; k < 2 && k < wr_addr_q.size(); k++) begin
            check_cnt++; if (wr_addr_q[k] !== 8'(k) || wr_data_q[k] !== words_q[k])
                $display("FAIL write%0d m%0d: got %h@%h want %h@%h", k, mode, wr_data_q[k], wr_addr_q[k], words_q[k], 8'(k)); else pass_cnt++;
        end
        pulse_reload();
    endtask

    task automatic test_bad_count(input logic [15:0] n);
        int cyc;
        words_q.delete();
        frame_q.delete();
        frame_q.push_back(n[7:0]);
        frame_q.push_back(n[15:8]);
        wr_addr_q.delete(); wr_data_q.delete();
        send_frame(0, cyc);
        check_cnt++; if (error !== 1'b1 || cpu_reset !== 1'b1 || s_ready !== 1'b0)
            $display("FAIL bad_n_%0d: got err=%b cpu_reset=%b ready=%b want 1/1/0", n, error, cpu_reset, s_ready); else pass_cnt++;
        s_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin s_data = 8'($urandom); @(negedge clk); end
        s_valid = 1'b0;
        check_cnt++; if (wr_addr_q.size() != 0 || s_ready !== 1'b0 || done !== 1'b0)
            $display("FAIL bad_n_%0d_idle: got writes=%0d ready=%b done=%b want 0/0/0", n, wr_addr_q.size(), s_ready, done); else pass_cnt++;
        pulse_reload();
        check_cnt++; if (error !== 1'b0 || s_ready !== 1'b1)
            $display("FAIL bad_n_%0d_reload: got err=%b ready=%b want 0/1", n, error, s_ready); else pass_cnt++;
    endtask

    task automatic test_reset_midload();
        int cyc;
        words_q = '{$urandom, $urandom};
        make_frame(16'd2, 32'd0);
        frame_q = frame_q[0:6];
        send_frame(0, cyc);
        #1 reset = 1'b0;
        #1;
        check_cnt++; if (s_ready !== 1'b0 || cpu_reset !== 1'b1 || words_loaded !== '0 || imem_we !== 1'b0)
            $display("FAIL midload_reset: got ready=%b cpu_reset=%b words=%0d we=%b want 0/1/0/0", s_ready, cpu_reset, words_loaded, imem_we); else pass_cnt++;
        @(negedge clk);
        reset = 1'b1;
        wr_addr_q.delete(); wr_data_q.delete();
        words_q = '{$urandom};
        make_frame(16'd1, 32'd0);
        send_frame(0, cyc);
        repeat (2) @(negedge clk);
        check_cnt++; if (wr_addr_q.size() != 1 || done !== 1'b1)
            $display("FAIL midload_reload: got writes=%0d done=%b want 1/1", wr_addr_q.size(), done); else pass_cnt++;
        if (wr_addr_q.size() > 0) begin
            check_cnt++; if (wr_addr_q[0] !== 8'd0 || wr_data_q[0] !== words_q[0])
                $display("FAIL midload_write: got %h@%h want %h@00", wr_data_q[0], wr_addr_q[0], words_q[0]); else pass_cnt++;
        end
    endtask

    task automatic test_reload();
        int cyc;
        check_cnt++; if (done !== 1'b1) $display("FAIL reload_pre: got done=%b want 1", done); else pass_cnt++;
        pulse_reload();
        check_cnt++; if (cpu_reset !== 1'b1 || done !== 1'b0 || words_loaded !== '0 || s_ready !== 1'b1)
            $display("FAIL reload: got cpu_reset=%b done=%b words=%0d ready=%b want 1/0/0/1", cpu_reset, done, words_loaded, s_ready); else pass_cnt++;
        wr_addr_q.delete(); wr_data_q.delete();
        words_q = '{$urandom};
        make_frame(16'd1, 32'd0);
        send_frame(1, cyc);
        @(negedge clk);
        check_cnt++; if (cpu_reset !== 1'b0 || done !== 1'b1 || wr_addr_q.size() != 1)
            $display("FAIL reload_load: got cpu_reset=%b done=%b writes=%0d want 0/1/1", cpu_reset, done, wr_addr_q.size()); else pass_cnt++;
    endtask

    task automatic test_random();
        int cyc;
        int n;
        for (int it = 0; it < 5; it++) begin
            pulse_reload();
            n = (it == 0) ? 256 : int'($urandom_range(1, 6));
            words_q.delete();
            for (int k = 0; k < n; k++) words_q.push_back($urandom);
            make_frame(16'(n), 32'd0);
            wr_addr_q.delete(); wr_data_q.delete();
            send_frame(2, cyc);
            repeat (2) @(negedge clk);
            check_cnt++; if (wr_addr_q.size() != n || words_loaded !== 9'(n) || done !== 1'b1 || cpu_reset !== 1'b0)
                $display("FAIL rand%0d_summary: got writes=%0d words=%0d done=%b cpu_reset=%b want %0d/%0d/1/0",
                         it, wr_addr_q.size(), words_loaded, done, cpu_reset, n, n); else pass_cnt++;
            for (int k = 0; k < n && k < wr_addr_q.size(); k++) begin
                check_cnt++; if (wr_addr_q[k] !== 8'(k) || wr_data_q[k] !== words_q[k])
                    $display("FAIL rand%0d_write%0d: got %h@%h want %h@%h", it, k, wr_data_q[k], wr_addr_q[k], words_q[k], 8'(k)); else pass_cnt++;
            end
        end
    endtask

`ifdef IMEM_BOOT_CHECKSUM_EN
    task automatic test_checksum();
        int cyc;
        pulse_reload();
        words_q = '{32'h2008_0005, 32'h2109_0003};
        make_frame(16'd2, 32'd1);
        check_cnt++; if (frame_q[10] !== 8'h09) $display("FAIL csum_model: got %h want 09", frame_q[10]); else pass_cnt++;
        send_frame(0, cyc);
        repeat (2) @(negedge clk);
        check_cnt++; if (error !== 1'b1 || cpu_reset !== 1'b1 || done !== 1'b0)
            $display("FAIL csum_bad: got err=%b cpu_reset=%b done=%b want 1/1/0", error, cpu_reset, done); else pass_cnt++;
        pulse_reload();
        make_frame(16'd2, 32'd0);
        send_frame(0, cyc);
        @(negedge clk);
        check_cnt++; if (error !== 1'b0 || cpu_reset !== 1'b0 || done !== 1'b1)
            $display("FAIL csum_good: got err=%b cpu_reset=%b done=%b want 0/0/1", error, cpu_reset, done); else pass_cnt++;
        pulse_reload();
    endtask
`endif

    initial begin
        test_reset();
        test_basic_load(0);
        test_basic_load(1);
        test_bad_count(16'd0);
        test_bad_count(16'd257);
        test_reset_midload();
        test_reload();
        test_random();
`ifdef IMEM_BOOT_CHECKSUM_EN
        test_checksum();
`endif
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

- Upstream stage of the single-cycle MIPS `Processor`.
- Receives a byte stream over a valid/ready link and assembles it into 32-bit instruction words.
- Writes each word into instruction memory, then releases the processor's reset so it executes the loaded program.
- Holds the core in reset for the entire load and on any load error.

## Interface
- `ADDR_WIDTH`, 8: instruction-memory word-address width; capacity `2**ADDR_WIDTH` words.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low; 0 clears all state.
- `s_valid` in 1: byte-stream valid.
- `s_data` in 8: byte-stream data.
- `s_ready` out 1: byte-stream ready, registered.
- `reload` in 1: single-cycle request to restart loading; honoured only in RUN or ERR.
- `imem_we` out 1: instruction-memory write strobe, one-cycle pulse per word.
- `imem_addr` out ADDR_WIDTH: word address.
- `imem_wdata` out 32: word data.
- `cpu_reset` out 1: active-high reset to `Processor`.
- `done` out 1: load complete, core running.
- `error` out 1: load aborted.
- `words_loaded` out ADDR_WIDTH+1: number of words written so far.

## Operation
- **Reset values (while `reset`=0):** state HDR_LO; `s_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `cpu_reset`=1, `done`=0, `error`=0, `words_loaded`=0.
- **Byte transfer:** a byte transfers on an edge where `s_valid`&`s_ready`.
- **Frame format:**
  - Count N: 16-bit, little-endian (low byte first).
  - Payload: N words, 4 bytes each, little-endian.
- **States:**
  - HDR_LO: accept byte → N[7:0]; go to HDR_HI.
  - HDR_HI: accept byte → N[15:8]. If N==0 or N>2**ADDR_WIDTH, go to ERR; otherwise go to DATA.
  - DATA: accumulate bytes. On the 4th byte of a word:
    - register `imem_we`=1, `imem_addr`=word index, `imem_wdata`=assembled word;
    - increment `words_loaded`.
    - After word N-1, go to FIN (or CHK if the checksum is configured).
  - FIN: one cycle. Set `cpu_reset`=0 and `done`=1; go to RUN.
  - RUN: `s_ready`=0; hold outputs. On `reload`, go to HDR_LO, set `cpu_reset`=1, `done`=0, `words_loaded`=0.
  - ERR: `s_ready`=0, `error`=1, `cpu_reset`=1. On `reload`, go to HDR_LO and clear `error`.
- **Byte counter:** 2-bit, wraps 3→0 at each word boundary.
- **Word index:** ADDR_WIDTH bits; never exceeds N-1.
- **`reload` elsewhere:** ignored in every state other than RUN and ERR.
- **Idle `s_valid`:** stalls the current state indefinitely with no timeout; bytes outside a transfer are never captured.

## Timing
- **`s_ready`:** registered and equal to the next state ∈ {HDR_LO, HDR_HI, DATA, CHK}.
  - It rises at the first edge after `reset` releases.
  - It falls on the same edge that accepts the final frame byte, so no extra byte is ever accepted.
- **Write latency:** `imem_we` is high for exactly the one cycle after the edge accepting a word's 4th byte. Address and data are stable during that cycle.
- **Release:** `cpu_reset` falls and `done` rises one cycle after the final `imem_we` pulse (FIN edge), so the last write completes before the core fetches.
- **Back-to-back streaming:** `s_valid` held high gives 1 byte per cycle with no bubbles.
- **Reset mid-load:** an asynchronous return to reset values; memory contents already written are left untouched.
- **`reload` timing:** a pulse in RUN re-asserts `cpu_reset` at the next edge.

## Configuration
- **`IMEM_BOOT_CHECKSUM_EN` defined:**
  - The frame carries 4 extra little-endian bytes after the payload: sum of all N words mod 2^32.
  - The CHK state accepts them.
  - On match, go to FIN. On mismatch, go to ERR and never release `cpu_reset`.
  - The running sum is updated at each word assembly and cleared on reset/`reload`.
- **Not defined:**
  - No CHK state and no checksum bytes.
  - DATA goes directly to FIN.
  - `error` is caused only by an invalid N.

## Test plan
- **Basic load:** N=2 (bytes 02 00), words 0x20080005, 0x21090003 streamed at full rate.
  - Response: `imem_we` pulses at addr 0 then 1 with those data.
  - `cpu_reset` falls one cycle after the 2nd pulse; `done`=1; `words_loaded`=2.
- **Throttled stream:** same frame with `s_valid` toggling every other cycle → identical writes, no duplicate or lost bytes.
- **Bad count:** N=0, and separately N=257 at ADDR_WIDTH=8 → ERR; `error`=1; `cpu_reset` stays 1; no `imem_we`; `s_ready`=0.
- **Reset mid-load:** `reset` pulled low after 5 payload bytes, then a fresh N=1 frame → exactly one write, at addr 0.
- **Reload:** in RUN, a `reload` pulse → `cpu_reset`=1 and `done`=0 next cycle; a new N=1 frame loads and releases again.
- **With `IMEM_BOOT_CHECKSUM_EN`:**
  - N=2 frame above with checksum 0x4111_0008 → RUN.
  - Checksum 0x4111_0009 → ERR with `error`=1.
